pc_fetch: RTL and testbench
===========================

// Module: pc_fetch
// PURPOSE
//  Fetch-side counterpart of the next-PC select path.
//  - Holds the architectural fetch PC.
//  - Drives PC+4 toward the next-PC mux and loads the mux result back.
//  - Issues instruction-memory reads with a valid/ready handshake.
//  - Buffers returned {pc, instr} pairs in a small FIFO for decode.
//  - Sits between the next-PC mux, instruction memory and the decode stage.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch PC loaded on reset
//  BUF_DEPTH  2              FIFO entries (power of 2, >=2)
// PORTS
//  i_clk           in   1   clock, all state on rising edge
//  i_reset         in   1   asynchronous, active-high reset
//  i_pc_sel        in   1   1 = redirect (branch/jump taken this cycle)
//  i_pc_next       in   32  next PC from mux (PC+4 or ALU target)
//  o_pc            out  32  current fetch PC
//  o_pc_four       out  32  o_pc + 4, to mux
//  o_imem_valid    out  1   read request valid
//  i_imem_ready    in   1   memory accepts request
//  o_imem_addr     out  32  request address (= o_pc while valid)
//  i_imem_rvalid   in   1   read data valid
//  i_imem_rdata    in   32  read data
//  o_instr_valid   out  1   FIFO not empty
//  i_instr_ready   in   1   decode consumes head entry
//  o_instr         out  32  head instruction
//  o_instr_pc      out  32  head instruction PC
//  o_misalign      out  1   redirect target misaligned (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, any state):
//    - o_pc = RESET_PC; FIFO emptied; state S_IDLE; kill = 0.
//    - o_imem_valid = 0, o_instr_valid = 0, o_instr = 0, o_instr_pc = 0, o_misalign = 0.
//  - o_pc_four = o_pc + 32'd4, combinational, wraps mod 2^32 (FFFF_FFFC -> 0).
//  - FSM:
//    - S_IDLE: -> S_REQ next cycle.
//    - S_REQ: o_imem_valid = 1 only while (count + outstanding) < BUF_DEPTH, else holds.
//      On valid & ready -> S_WAIT.
//    - S_WAIT: on i_imem_rvalid, then -> S_REQ.
//      - kill = 0: push {o_pc, rdata}; o_pc <= i_pc_next.
//      - kill = 1: drop data; clear kill; o_pc unchanged.
//  - Single outstanding request. o_imem_addr is stable while valid and not ready.
//  - Redirect (i_pc_sel = 1) in any state:
//    - o_pc <= i_pc_next; FIFO flushed the same edge.
//    - S_WAIT, or S_REQ with handshake this cycle: kill <= 1, so the stale response is dropped.
//    - S_REQ with no handshake: o_imem_valid drops one cycle, then re-requests the new o_pc.
//    - Redirect plus rvalid in the same cycle: data dropped, kill stays 0, o_pc <= i_pc_next.
//  - FIFO:
//    - Pop when o_instr_valid & i_instr_ready.
//    - Simultaneous push/pop keeps count.
//    - Overflow cannot occur because of the issue rule above.
//    - Pop while flushing is ignored.
//  - Latency: request accepted at cycle t with rdata at t+k puts the entry at the FIFO head at t+k+1.
// CONFIGURATION
//  FETCH_MISALIGN_CHK_EN defined:
//    - Redirect with i_pc_next[1:0] != 0 pulses o_misalign for 1 cycle.
//    - o_pc loads {i_pc_next[31:2], 2'b00}.
//  FETCH_MISALIGN_CHK_EN undefined:
//    - o_misalign tied 0.
//    - o_pc loads i_pc_next unmodified.
// TESTING
//  1 Reset with RESET_PC = 0, mem ready = 1, rvalid 1 cycle after accept
//    -> addrs 0,4,8 issued; FIFO heads {0,I0},{4,I1} in order.
//  2 Decode ready = 0 with BUF_DEPTH = 2
//    -> 2 entries fill, o_imem_valid stays 0; ready = 1 -> fetch resumes at 0x8.
//  3 Redirect to 0x100 while in S_WAIT for 0x8
//    -> 0x8 data dropped, FIFO empty, next request addr 0x100.
//  4 i_imem_ready = 0 for 3 cycles -> o_imem_addr holds 0x0, no FIFO push.
//  5 Assert i_reset mid-S_WAIT
//    -> outputs reset immediately; the late rvalid after release is ignored (state S_IDLE).
//  6 FETCH_MISALIGN_CHK_EN, redirect to 0x102
//    -> o_misalign = 1 for one cycle, next addr 0x100; macro off -> addr 0x102, o_misalign = 0.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle: next-PC mux link, instruction-memory handshake and decode-side FIFO head.
// master = pc_fetch itself, slave = the surrounding pipeline/memory.
interface pc_fetch_if;
  logic        i_pc_sel;
  logic [31:0] i_pc_next;
  logic [31:0] o_pc;
  logic [31:0] o_pc_four;
  logic        o_imem_valid;
  logic        i_imem_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        o_misalign;

  modport master (
    input  i_pc_sel, i_pc_next, i_imem_ready, i_imem_rvalid, i_imem_rdata, i_instr_ready,
    output o_pc, o_pc_four, o_imem_valid, o_imem_addr, o_instr_valid, o_instr, o_instr_pc,
           o_misalign
  );

  modport slave (
    output i_pc_sel, i_pc_next, i_imem_ready, i_imem_rvalid, i_imem_rdata, i_instr_ready,
    input  o_pc, o_pc_four, o_imem_valid, o_imem_addr, o_instr_valid, o_instr, o_instr_pc,
           o_misalign
  );
endinterface

// File: rtl/pc_fetch.sv
// Fetch PC register, single-outstanding imem request FSM and {pc, instr} FIFO toward decode.
// Optional build macro FETCH_MISALIGN_CHK_EN: word-align redirect targets and flag misaligned ones.
module pc_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input logic       i_clk,
  input logic       i_reset,
  pc_fetch_if.master bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic               kill_q, kill_d;
  logic               misalign_q, misalign_d;
  logic [31:0]        pc_q, pc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        buf_pc_q    [BUF_DEPTH];
  logic [31:0]        buf_instr_q [BUF_DEPTH];

  logic        imem_valid, hs, push, pop, flush;
  logic [31:0] redirect_pc;

  // Only one request may be in flight, so nothing is outstanding while in S_REQ.
  assign imem_valid = (state_q == S_REQ) && (count_q < CNT_W'(BUF_DEPTH));
  assign hs         = imem_valid && bus.i_imem_ready;

  always_comb begin
`ifdef FETCH_MISALIGN_CHK_EN
    redirect_pc = {bus.i_pc_next[31:2], 2'b00};
    misalign_d  = bus.i_pc_sel && (bus.i_pc_next[1:0] != 2'b00);
`else
    redirect_pc = bus.i_pc_next;
    misalign_d  = 1'b0;
`endif
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  if (hs) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.i_imem_rvalid) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
          if (!kill_q && !bus.i_pc_sel) begin
            push = 1'b1;
            pc_d = bus.i_pc_next;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect overrides everything; a response still to come for the old path must be killed.
    if (bus.i_pc_sel) begin
      pc_d  = redirect_pc;
      flush = 1'b1;
      if ((state_q == S_WAIT && !bus.i_imem_rvalid) || (state_q == S_REQ && hs))
        kill_d = 1'b1;
      else if (state_q == S_REQ)
        state_d = S_IDLE;
    end
  end

  assign pop = (count_q != '0) && bus.i_instr_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      kill_q     <= 1'b0;
      misalign_q <= 1'b0;
      pc_q       <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      misalign_q <= misalign_d;
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count_q gates every read of it.
  always_ff @(posedge i_clk) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]    <= pc_q;
      buf_instr_q[wr_ptr_q] <= bus.i_imem_rdata;
    end
  end

  assign bus.o_pc          = pc_q;
  assign bus.o_pc_four     = pc_q + 32'd4;
  assign bus.o_imem_valid  = imem_valid;
  assign bus.o_imem_addr   = pc_q;
  assign bus.o_instr_valid = (count_q != '0);
  assign bus.o_instr       = (count_q != '0) ? buf_instr_q[rd_ptr_q] : 32'd0;
  assign bus.o_instr_pc    = (count_q != '0) ? buf_pc_q[rd_ptr_q]    : 32'd0;
  assign bus.o_misalign    = misalign_q;
endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: fill/stall, redirect with kill, imem back-pressure, async reset,
// misaligned redirect and PC+4 wrap. Instruction memory returns 0xC000_0000 | addr.
module tb_pc_fetch;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic [31:0] MIS_ADDR = 32'h0000_0100;
  localparam logic [31:0] MIS_FLAG = 32'd1;
`else
  localparam logic [31:0] MIS_ADDR = 32'h0000_0102;
  localparam logic [31:0] MIS_FLAG = 32'd0;
`endif

  logic        clk;
  logic        rst;
  logic        pc_sel;
  logic [31:0] target;
  logic        resp_en;
  int          resp_lat;
  logic        rvalid_auto, rvalid_man;
  logic [31:0] rdata_auto, rdata_man, resp_addr;
  int          n_chk, n_err;

  pc_fetch_if bus ();

  pc_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.master)
  );

  // Next-PC mux model: PC+4 unless redirecting.
  assign bus.i_pc_sel      = pc_sel;
  assign bus.i_pc_next     = pc_sel ? target : bus.o_pc_four;
  assign bus.i_imem_rvalid = rvalid_auto | rvalid_man;
  assign bus.i_imem_rdata  = rvalid_man ? rdata_man : rdata_auto;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: accept seen mid-cycle, data valid for one cycle resp_lat edges later.
  initial begin
    rvalid_auto = 1'b0;
    rdata_auto  = '0;
  end
  always begin
    @(negedge clk);
    if (resp_en && bus.o_imem_valid && bus.i_imem_ready) begin
      resp_addr = bus.o_imem_addr;
      repeat (resp_lat) @(posedge clk);
      #1;
      rvalid_auto = 1'b1;
      rdata_auto  = 32'hC000_0000 | resp_addr;
      @(posedge clk);
      #1;
      rvalid_auto = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    pc_sel = 1'b0;
    target = '0;
    resp_en = 1'b1;
    resp_lat = 1;
    rvalid_man = 1'b0;
    rdata_man = '0;
    bus.i_imem_ready  = 1'b1;
    bus.i_instr_ready = 1'b0;

    #2;
    check("rst_pc", bus.o_pc, 32'h0);
    check("rst_pc_four", bus.o_pc_four, 32'h4);
    check("rst_imem_valid", 32'(bus.o_imem_valid), 32'd0);
    check("rst_instr_valid", 32'(bus.o_instr_valid), 32'd0);
    check("rst_instr", bus.o_instr, 32'h0);
    check("rst_instr_pc", bus.o_instr_pc, 32'h0);
    check("rst_misalign", 32'(bus.o_misalign), 32'd0);
    #10 rst = 1'b0;

    // Fill: requests 0 and 4 land in the FIFO, decode stalled.
    cyc(1);
    check("req0_valid", 32'(bus.o_imem_valid), 32'd1);
    check("req0_addr", bus.o_imem_addr, 32'h0);
    cyc(2);
    check("head0_valid", 32'(bus.o_instr_valid), 32'd1);
    check("head0_pc", bus.o_instr_pc, 32'h0);
    check("head0_instr", bus.o_instr, 32'hC000_0000);
    check("req4_addr", bus.o_imem_addr, 32'h4);
    cyc(2);
    check("full_valid", 32'(bus.o_imem_valid), 32'd0);
    check("full_addr", bus.o_imem_addr, 32'h8);
    check("full_pc_four", bus.o_pc_four, 32'hC);
    cyc(3);
    check("full_hold_valid", 32'(bus.o_imem_valid), 32'd0);
    check("full_hold_head", bus.o_instr_pc, 32'h0);

    // Drain: second entry reaches head, fetch resumes at 0x8.
    bus.i_instr_ready = 1'b1;
    cyc(1);
    check("head1_pc", bus.o_instr_pc, 32'h4);
    check("head1_instr", bus.o_instr, 32'hC000_0004);
    check("resume_valid", 32'(bus.o_imem_valid), 32'd1);
    check("resume_addr", bus.o_imem_addr, 32'h8);
    resp_lat = 3;

    // Redirect to 0x100 while waiting on 0x8.
    cyc(1);
    check("wait8_empty", 32'(bus.o_instr_valid), 32'd0);
    check("wait8_valid", 32'(bus.o_imem_valid), 32'd0);
    pc_sel = 1'b1;
    target = 32'h100;
    cyc(1);
    pc_sel = 1'b0;
    check("redir_pc", bus.o_imem_addr, 32'h100);
    check("redir_wait_valid", 32'(bus.o_imem_valid), 32'd0);
    cyc(2);
    check("kill_valid", 32'(bus.o_imem_valid), 32'd1);
    check("kill_addr", bus.o_imem_addr, 32'h100);
    check("kill_empty", 32'(bus.o_instr_valid), 32'd0);
    resp_lat = 1;

    // imem back-pressure for 3 cycles.
    bus.i_imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("stall_addr", bus.o_imem_addr, 32'h100);
      check("stall_valid", 32'(bus.o_imem_valid), 32'd1);
      check("stall_empty", 32'(bus.o_instr_valid), 32'd0);
    end
    bus.i_imem_ready = 1'b1;
    cyc(2);
    check("lat_valid", 32'(bus.o_instr_valid), 32'd1);
    check("lat_pc", bus.o_instr_pc, 32'h100);
    check("lat_instr", bus.o_instr, 32'hC000_0100);
    check("lat_next_addr", bus.o_imem_addr, 32'h104);
    bus.i_instr_ready = 1'b0;
    cyc(2);
    check("refull_valid", 32'(bus.o_imem_valid), 32'd0);
    check("refull_addr", bus.o_imem_addr, 32'h108);
    check("refull_head", bus.o_instr_pc, 32'h100);

    // Redirect with a full FIFO and no request in flight; pop during flush ignored.
    pc_sel = 1'b1;
    target = 32'h200;
    bus.i_instr_ready = 1'b1;
    cyc(1);
    pc_sel = 1'b0;
    bus.i_instr_ready = 1'b0;
    check("flush_empty", 32'(bus.o_instr_valid), 32'd0);
    check("flush_gap_valid", 32'(bus.o_imem_valid), 32'd0);
    check("flush_addr", bus.o_imem_addr, 32'h200);
    resp_en = 1'b0;
    cyc(1);
    check("rereq_valid", 32'(bus.o_imem_valid), 32'd1);
    check("rereq_addr", bus.o_imem_addr, 32'h200);

    // Async reset in S_WAIT; a late response after release must be ignored.
    cyc(1);
    check("wait200_valid", 32'(bus.o_imem_valid), 32'd0);
    rst = 1'b1;
    #1;
    check("async_rst_pc", bus.o_pc, 32'h0);
    check("async_rst_valid", 32'(bus.o_imem_valid), 32'd0);
    #1;
    rst = 1'b0;
    rvalid_man = 1'b1;
    rdata_man = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    rvalid_man = 1'b0;
    #1;
    check("late_rvalid_empty", 32'(bus.o_instr_valid), 32'd0);
    check("late_rvalid_addr", bus.o_imem_addr, 32'h0);
    check("late_rvalid_valid", 32'(bus.o_imem_valid), 32'd1);

    // Misaligned redirect coinciding with a handshake (kill path).
    resp_en = 1'b1;
    pc_sel = 1'b1;
    target = 32'h102;
    cyc(1);
    pc_sel = 1'b0;
    check("mis_addr", bus.o_imem_addr, MIS_ADDR);
    check("mis_flag", 32'(bus.o_misalign), MIS_FLAG);
    check("mis_empty", 32'(bus.o_instr_valid), 32'd0);
    cyc(1);
    check("mis_pulse_end", 32'(bus.o_misalign), 32'd0);
    check("mis_req_valid", 32'(bus.o_imem_valid), 32'd1);
    check("mis_req_addr", bus.o_imem_addr, MIS_ADDR);
    check("mis_drop_empty", 32'(bus.o_instr_valid), 32'd0);
    cyc(2);
    check("mis_head_pc", bus.o_instr_pc, MIS_ADDR);
    check("mis_head_instr", bus.o_instr, 32'hC000_0000 | MIS_ADDR);

    // PC+4 wraps at the top of the address space.
    pc_sel = 1'b1;
    target = 32'hFFFF_FFFC;
    cyc(1);
    pc_sel = 1'b0;
    check("wrap_pc", bus.o_pc, 32'hFFFF_FFFC);
    check("wrap_pc_four", bus.o_pc_four, 32'h0);
    check("wrap_flush", 32'(bus.o_instr_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
